// File: rtl/time_entry_register_if.sv
// Keypad-encoder to time-entry bus: encoder strobes in, BCD MM:SS entry and status out.
interface time_entry_register_if;
    logic       load;
    logic [3:0] digit;
    logic       entry_en;
    logic       clr_entry;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [2:0] digit_count;
    logic       full;
    logic       time_nonzero;
    logic       accepted;
    logic       rejected;

    modport slave (
        input  load, digit, entry_en, clr_entry,
        output sec_ones, sec_tens, min_ones, min_tens,
        output digit_count, full, time_nonzero, accepted, rejected
    );

    modport master (
        output load, digit, entry_en, clr_entry,
        input  sec_ones, sec_tens, min_ones, min_tens,
        input  digit_count, full, time_nonzero, accepted, rejected
    );
endinterface

// File: rtl/time_entry_register.sv
// Debounces the keypad load strobe and shifts accepted BCD digits right-to-left
// into a 4-digit MM:SS cooking-time entry, with entry count and accept/reject pulses.
module time_entry_register #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned MAX_DIGITS      = 4
) (
    input  logic                  clk,
    input  logic                  clearn,
    time_entry_register_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] DEB_C = 4'(DEBOUNCE_CYCLES);
    localparam logic [2:0] MAX_C = 3'(MAX_DIGITS);

    function automatic logic bcd_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    function automatic logic any_nonzero(input logic [15:0] digits);
        return (digits != 16'd0);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  qcnt_q, qcnt_d;
    logic [15:0] digits_q, digits_d;   // {min_tens, min_ones, sec_tens, sec_ones}
    logic [2:0]  count_q, count_d;
    logic        acc_q, acc_d;
    logic        rej_q, rej_d;
    logic        commit_s;

    // Press sequencing: only load drives the FSM, one commit per qualified press.
    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    state_d = ST_QUAL;
                    qcnt_d  = 4'd1;
                end else begin
                    qcnt_d  = 4'd0;
                end
            end
            ST_QUAL: begin
                if (!bus.load) begin
                    state_d = ST_IDLE;
                    qcnt_d  = 4'd0;
                end else if (qcnt_q >= DEB_C) begin
                    commit_s = 1'b1;
                    state_d  = ST_HOLD;
                    qcnt_d   = 4'd0;
                end else begin
                    qcnt_d   = qcnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!bus.load) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
                qcnt_d = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                qcnt_d  = 4'd0;
            end
        endcase
    end

    // Commit decision: a clear wins over everything and silently drops a same-edge commit.
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        acc_d    = 1'b0;
        rej_d    = 1'b0;
        if (bus.clr_entry) begin
            digits_d = 16'd0;
            count_d  = 3'd0;
        end else if (commit_s) begin
            if (!bus.entry_en || !bcd_valid(bus.digit) || (count_q >= MAX_C)) begin
                rej_d = 1'b1;
            end else begin
                digits_d = {digits_q[11:0], bus.digit};
                count_d  = count_q + 3'd1;
                acc_d    = 1'b1;
            end
        end else begin
            acc_d = 1'b0;
            rej_d = 1'b0;
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q  <= ST_IDLE;
            qcnt_q   <= 4'd0;
            digits_q <= 16'd0;
            count_q  <= 3'd0;
            acc_q    <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rej_q    <= rej_d;
        end
    end

    assign bus.sec_ones     = digits_q[3:0];
    assign bus.sec_tens     = digits_q[7:4];
    assign bus.min_ones     = digits_q[11:8];
    assign bus.min_tens     = digits_q[15:12];
    assign bus.digit_count  = count_q;
    assign bus.full         = (count_q == MAX_C);
    assign bus.time_nonzero = any_nonzero(digits_q);
    assign bus.accepted     = acc_q;
    assign bus.rejected     = rej_q;

endmodule

// File: tb/tb_time_entry_register.sv
// Randomised and directed stimulus for time_entry_register, checked every cycle against
// a decimal-arithmetic model of the entry plus a run-length model of the debounce.
module tb_time_entry_register;

    localparam int DEB  = 2;
    localparam int MAXD = 4;

    logic clk    = 1'b0;
    logic clearn = 1'b0;

    time_entry_register_if tif();

    time_entry_register #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_DIGITS(MAXD)
    ) dut (
        .clk(clk),
        .clearn(clearn),
        .bus(tif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_seen = 0;
    int rej_seen = 0;

    // Model: m_val is the entry as a decimal number, m_run the count of consecutive high load samples.
    int m_run = 0;
    int m_val = 0;
    int m_cnt = 0;
    int m_acc = 0;
    int m_rej = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            m_run <= 0;
            m_val <= 0;
            m_cnt <= 0;
            m_acc <= 0;
            m_rej <= 0;
        end else begin
            m_acc <= 0;
            m_rej <= 0;
            if (tif.load) m_run <= (m_run < 1000) ? m_run + 1 : m_run;
            else          m_run <= 0;
            if (tif.clr_entry) begin
                m_val <= 0;
                m_cnt <= 0;
            end else if (tif.load && m_run == DEB) begin
                if (!tif.entry_en || int'(tif.digit) > 9 || m_cnt == MAXD) begin
                    m_rej <= 1;
                end else begin
                    m_val <= m_val * 10 + int'(tif.digit);
                    m_cnt <= m_cnt + 1;
                    m_acc <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("sec_ones",     int'(tif.sec_ones),     m_val % 10);
        chk("sec_tens",     int'(tif.sec_tens),     (m_val / 10) % 10);
        chk("min_ones",     int'(tif.min_ones),     (m_val / 100) % 10);
        chk("min_tens",     int'(tif.min_tens),     (m_val / 1000) % 10);
        chk("digit_count",  int'(tif.digit_count),  m_cnt);
        chk("full",         int'(tif.full),         (m_cnt == MAXD) ? 1 : 0);
        chk("time_nonzero", int'(tif.time_nonzero), (m_val != 0) ? 1 : 0);
        chk("accepted",     int'(tif.accepted),     m_acc);
        chk("rejected",     int'(tif.rejected),     m_rej);
        if (tif.accepted) acc_seen++;
        if (tif.rejected) rej_seen++;
    end

    function automatic int entry_hex();
        return int'({tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones});
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tif.load  = 1'b1;
            tif.digit = d;
            step();
        end
        tif.load  = 1'b0;
        tif.digit = 4'($urandom_range(0, 15));
        for (int i = 0; i < gap; i++) step();
    endtask

    task automatic clear_entry();
        tif.clr_entry = 1'b1;
        step();
        tif.clr_entry = 1'b0;
        step();
    endtask

    initial begin
        int a0;
        int r0;
        int n;
        int gap;
        logic [3:0] d;

        tif.load      = 1'b0;
        tif.digit     = 4'd0;
        tif.entry_en  = 1'b1;
        tif.clr_entry = 1'b0;
        repeat (3) step();
        chk("reset_entry", entry_hex(), 0);
        chk("reset_count", int'(tif.digit_count), 0);
        clearn = 1'b1;
        step();

        // First press, load held 4 cycles: exactly one accept.
        a0 = acc_seen;
        press(4'd1, 4, 2);
        chk("p1_accepts", acc_seen - a0, 1);
        chk("p1_sec_ones", int'(tif.sec_ones), 1);
        chk("p1_count", int'(tif.digit_count), 1);
        chk("p1_model", m_val, 1);

        press(4'd2, 3, 2);
        press(4'd3, 5, 1);
        press(4'd0, 3, 2);
        chk("p4_entry", entry_hex(), 'h1230);
        chk("p4_full", int'(tif.full), 1);
        chk("p4_nonzero", int'(tif.time_nonzero), 1);
        chk("p4_model", m_val, 1230);
        r0 = rej_seen;
        press(4'd5, 3, 2);
        chk("p5_rejects", rej_seen - r0, 1);
        chk("p5_entry", entry_hex(), 'h1230);

        // Single-cycle glitch is filtered.
        a0 = acc_seen;
        r0 = rej_seen;
        press(4'd7, 1, 2);
        chk("glitch_acc", acc_seen - a0, 0);
        chk("glitch_rej", rej_seen - r0, 0);
        chk("glitch_entry", entry_hex(), 'h1230);

        // Non-BCD code and disabled entry are refused.
        clear_entry();
        press(4'd4, 3, 2);
        r0 = rej_seen;
        press(4'hA, 3, 2);
        chk("hexA_rejects", rej_seen - r0, 1);
        chk("hexA_count", int'(tif.digit_count), 1);
        tif.entry_en = 1'b0;
        press(4'd5, 3, 2);
        tif.entry_en = 1'b1;
        chk("dis_rejects", rej_seen - r0, 2);
        chk("dis_count", int'(tif.digit_count), 1);

        // Clear on the commit edge discards the commit.
        clear_entry();
        press(4'd1, 3, 2);
        press(4'd2, 3, 2);
        chk("pre_clr_entry", entry_hex(), 'h0012);
        a0 = acc_seen;
        r0 = rej_seen;
        tif.load  = 1'b1;
        tif.digit = 4'd9;
        step();
        step();
        tif.clr_entry = 1'b1;
        step();
        tif.clr_entry = 1'b0;
        step();
        tif.load = 1'b0;
        step();
        step();
        chk("clr_commit_acc", acc_seen - a0, 0);
        chk("clr_commit_rej", rej_seen - r0, 0);
        chk("clr_commit_entry", entry_hex(), 0);
        chk("clr_commit_count", int'(tif.digit_count), 0);
        press(4'd9, 3, 2);
        chk("repress_sec_ones", int'(tif.sec_ones), 9);

        // Reset during HOLD; key held through reset release must requalify.
        clear_entry();
        press(4'd4, 3, 2);
        press(4'd5, 3, 2);
        chk("pre_rst_entry", entry_hex(), 'h0045);
        tif.load  = 1'b1;
        tif.digit = 4'd7;
        repeat (4) step();
        clearn = 1'b0;
        #1;
        chk("rst_hold_entry", entry_hex(), 0);
        chk("rst_hold_count", int'(tif.digit_count), 0);
        step();
        step();
        clearn = 1'b1;
        a0 = acc_seen;
        repeat (4) step();
        tif.load = 1'b0;
        step();
        step();
        chk("rst_release_acc", acc_seen - a0, 1);
        chk("rst_release_sec_ones", int'(tif.sec_ones), 7);

        // Randomised presses with occasional clears and resets.
        for (int k = 0; k < 250; k++) begin
            n   = $urandom_range(1, 5);
            gap = $urandom_range(1, 3);
            d   = 4'($urandom_range(0, 11));
            tif.entry_en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < n; i++) begin
                tif.load      = 1'b1;
                tif.digit     = d;
                tif.clr_entry = ($urandom_range(0, 24) == 0);
                clearn        = ($urandom_range(0, 79) != 0);
                step();
            end
            tif.clr_entry = 1'b0;
            clearn        = 1'b1;
            tif.load      = 1'b0;
            for (int i = 0; i < gap; i++) step();
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
